// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmitter that drains the CREM FIFO.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..prescale-1 and pulses bit_done on the last
// cycle of each bit. Wraps to 0 on its own so consecutive bits need no restart.
module uart_tx_bit_timer #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      restart,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] cnt;

  // prescale is the latched, already non-zero value, so prescale-1 never underflows
  assign bit_done = (cnt == (prescale - ONE));

  // Hold at zero while restarted, otherwise count up and wrap at the bit boundary.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (restart || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from the FIFO read port and sends each as a UART frame:
// start bit, data LSB first, optional parity, one stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a non-empty FIFO
// START  | driving the start bit
// DATA   | shifting out data bits, LSB first
// PARITY | driving the parity bit (only when parity latched enabled)
// STOP   | driving the stop bit; last cycle may pop the next byte
module uart_tx_fifo_drain
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EMPTY,
  input  logic [DATA_WIDTH-1:0]     RD_DATA,
  output logic                      R_INC,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE = PRESCALE_WIDTH'(1);

  tx_state_t                 state, state_nxt;
  logic [DATA_WIDTH-1:0]     shift_q, shift_nxt;
  logic [IDX_W-1:0]          bit_idx;
  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic                      tx_q, tx_nxt;
  logic                      pop;
  logic                      bit_done;

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .restart  (state == IDLE),
    .prescale (presc_q),
    .bit_done (bit_done)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and pop strobe; EMPTY only matters at the two pop points.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!EMPTY) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) state_nxt = DATA;
      end
      DATA: begin
        if (bit_done && (bit_idx == LAST_BIT)) begin
          state_nxt = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_done) state_nxt = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (!EMPTY) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (RST) pop = 1'b0;
  end

  // Line level for the next cycle follows the state being entered.
  always_comb begin
    shift_nxt = shift_q;
    if (pop) begin
      shift_nxt = RD_DATA;
    end else if ((state == DATA) && bit_done) begin
      shift_nxt = shift_q >> 1;
    end
    case (state_nxt)
      START:   tx_nxt = START_LVL;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_bit_q;
      STOP:    tx_nxt = STOP_LVL;
      default: tx_nxt = IDLE_LVL;
    endcase
  end

  // Datapath: shift register, bit index, per-frame config latched at the pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q   <= '0;
      bit_idx   <= '0;
      presc_q   <= PS_ONE;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= IDLE_LVL;
    end else begin
      shift_q <= shift_nxt;
      tx_q    <= tx_nxt;
      if (pop) begin
        bit_idx   <= '0;
        presc_q   <= (PRESCALE == '0) ? PS_ONE : PRESCALE;
        par_en_q  <= PAR_EN;
        par_bit_q <= (^RD_DATA) ^ (PAR_TYP == PAR_ODD);
      end else if ((state == DATA) && bit_done) begin
        bit_idx <= bit_idx + IDX_ONE;
      end
    end
  end

  assign R_INC  = pop;
  assign TX_OUT = tx_q;
  assign BUSY   = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Randomised and directed bench for uart_tx_fifo_drain. A queue-based FIFO
// feeds the DUT; a line model expands each popped byte into its per-cycle
// waveform and is compared every cycle.
module tb_uart_tx_fifo_drain;

  logic       clk;
  logic       rst;
  logic       empty;
  logic [7:0] rd_data;
  logic       r_inc;
  logic       par_en;
  logic       par_typ;
  logic [7:0] prescale;
  logic       tx_out;
  logic       busy;

  uart_tx_fifo_drain #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (8)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .EMPTY    (empty),
    .RD_DATA  (rd_data),
    .R_INC    (r_inc),
    .PAR_EN   (par_en),
    .PAR_TYP  (par_typ),
    .PRESCALE (prescale),
    .TX_OUT   (tx_out),
    .BUSY     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int busy_cnt = 0;
  int last_pop = 0;
  int prev_pop = 0;

  logic [7:0] fifo[$];
  logic       exp_q[$];
  logic       gate_empty = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expand one frame into per-cycle line levels.
  task automatic push_frame(input logic [7:0] d, input logic en, input logic typ,
                            input logic [7:0] ps);
    int   p;
    logic lv[$];
    p = (ps == 0) ? 1 : int'(ps);
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(d[i]);
    if (en) lv.push_back((^d) ^ typ);
    lv.push_back(1'b1);
    foreach (lv[i]) begin
      for (int k = 0; k < p; k++) exp_q.push_back(lv[i]);
    end
  endtask

  task automatic drive_fifo();
    empty   = gate_empty || (fifo.size() == 0);
    rd_data = (fifo.size() != 0) ? fifo[0] : 8'($urandom);
  endtask

  // One clock: check at the falling edge, advance the model, then re-drive inputs.
  task automatic tick();
    logic exp_tx, exp_busy, exp_pop;
    @(negedge clk);
    exp_tx   = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
    exp_busy = (exp_q.size() != 0);
    exp_pop  = !rst && !empty && (exp_q.size() <= 1);
    chk("r_inc", r_inc, exp_pop);
    chk("tx_out", tx_out, exp_tx);
    chk("busy", busy, exp_busy);
    if (busy === 1'b1) busy_cnt++;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    if (rst) exp_q.delete();
    else if (exp_pop) push_frame(rd_data, par_en, par_typ, prescale);
    if (r_inc === 1'b1) begin
      pop_cnt++;
      prev_pop = last_pop;
      last_pop = cyc;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_fifo();
  endtask

  initial begin
    rst = 1'b1; par_en = 1'b0; par_typ = 1'b0; prescale = 8'd1;
    gate_empty = 1'b1;
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    repeat (3) tick();
    rst = 1'b0;
    gate_empty = 1'b0;
    drive_fifo();
    tick();

    // even parity, P=4
    prescale = 8'd4; par_en = 1'b1; par_typ = 1'b0;
    fifo.push_back(8'hA5); drive_fifo();
    busy_cnt = 0; pop_cnt = 0;
    repeat (60) tick();
    chk("even_busy_len", busy_cnt, 44);
    chk("even_pops", pop_cnt, 1);

    // odd parity
    par_typ = 1'b1;
    fifo.push_back(8'hA5); drive_fifo();
    busy_cnt = 0; pop_cnt = 0;
    repeat (60) tick();
    chk("odd_busy_len", busy_cnt, 44);

    // no parity
    par_en = 1'b0;
    fifo.push_back(8'hA5); drive_fifo();
    busy_cnt = 0;
    repeat (50) tick();
    chk("nopar_busy_len", busy_cnt, 40);

    // back-to-back, P=2
    prescale = 8'd2;
    fifo.push_back(8'h01); fifo.push_back(8'h80); drive_fifo();
    busy_cnt = 0; pop_cnt = 0;
    repeat (50) tick();
    chk("b2b_pops", pop_cnt, 2);
    chk("b2b_gap", last_pop - prev_pop, 20);
    chk("b2b_busy_len", busy_cnt, 40);

    // empty idle, then release
    gate_empty = 1'b1;
    fifo.push_back(8'h5C); drive_fifo();
    pop_cnt = 0; busy_cnt = 0;
    repeat (100) tick();
    chk("idle_pops", pop_cnt, 0);
    chk("idle_busy", busy_cnt, 0);
    gate_empty = 1'b0; drive_fifo();
    tick();
    chk("release_pop", pop_cnt, 1);
    repeat (30) tick();

    // reset during data bit 3 of 0x3C
    prescale = 8'd4;
    fifo.push_back(8'h3C); fifo.push_back(8'h5A); drive_fifo();
    pop_cnt = 0; busy_cnt = 0;
    repeat (18) tick();
    gate_empty = 1'b1; rst = 1'b1; drive_fifo();
    tick();
    rst = 1'b0; drive_fifo();
    tick();
    gate_empty = 1'b0; drive_fifo();
    repeat (60) tick();
    chk("rst_pops", pop_cnt, 2);
    chk("rst_busy_len", busy_cnt, 58);

    // prescale 0 behaves as 1
    prescale = 8'd0;
    fifo.push_back(8'hC3); drive_fifo();
    busy_cnt = 0;
    repeat (15) tick();
    chk("ps0_busy_len", busy_cnt, 10);

    // prescale change 4 -> 8 mid-frame
    prescale = 8'd4;
    fifo.push_back(8'h96); fifo.push_back(8'h69); drive_fifo();
    busy_cnt = 0; pop_cnt = 0;
    repeat (10) tick();
    prescale = 8'd8;
    repeat (140) tick();
    chk("ps_chg_gap", last_pop - prev_pop, 40);
    chk("ps_chg_busy_len", busy_cnt, 120);

    // random traffic, config churn and occasional reset
    for (int i = 0; i < 1500; i++) begin
      if (($urandom_range(0, 3) == 0) && (fifo.size() < 4)) fifo.push_back(8'($urandom));
      par_en     = 1'($urandom);
      par_typ    = 1'($urandom);
      prescale   = 8'($urandom_range(0, 3));
      gate_empty = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      drive_fifo();
      tick();
    end
    rst = 1'b0; gate_empty = 1'b0; drive_fifo();
    repeat (60) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
